jk_excite_driver: RTL and testbench

//  Drives a JK flip-flop so that its output q follows a requested bit pattern.

---
 rtl/jk_excite_driver.sv | 158 +++++++++++++++
 tb/tb_jk_excite_driver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_driver.sv
// jk_excite_driver: closed-loop stimulus driver for a JK flip-flop.
// Accepts a bit pattern over a valid/ready handshake, then issues one
// registered (j,k) pair per cycle so the flop's q walks through the pattern.
// The fed-back q is compared against the expected sequence and mismatches
// are pulsed and counted (saturating).
// Build option: define JK_EXCITE_TOGGLE_EN to drive every change of state
// as a toggle (j=1,k=1) instead of set/reset.
//
// Handshake: a pattern is taken on a rising clk edge where
// pat_valid && pat_ready; pat_data/pat_len are latched on that edge.
// pat_ready is high only in IDLE. pat_valid is ignored at all other times.
module jk_excite_driver #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8,
    localparam int LW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [WIDTH-1:0] pat_data,
    input  logic [LW-1:0]    pat_len,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             busy,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic             done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  shift_q, shift_nx;
    logic [LW-1:0]     rem_q, rem_nx;
    logic              q_model, q_model_nx;
    logic              j_nx, k_nx, done_nx;
    logic              q_prev;
    logic              cmp_en;
    logic              cmp_fail;
    logic              accept;
    logic [LW-1:0]     len_eff;

    // Excitation from current modelled q (c) to target bit (t).
    function automatic logic [1:0] excite(input logic c, input logic t);
        if (c == t) begin
            return 2'b00;
        end
`ifdef JK_EXCITE_TOGGLE_EN
        return 2'b11;
`else
        return t ? 2'b10 : 2'b01;
`endif
    endfunction

    // A length of zero, or anything beyond WIDTH, means a full-width pattern.
    assign len_eff = ((pat_len == '0) || (pat_len > LW'(WIDTH))) ? LW'(WIDTH) : pat_len;

    assign accept    = pat_valid && (state == IDLE);
    assign pat_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // q_prev holds the bit issued one cycle earlier, i.e. what an ideal flop
    // shows now; cmp_en marks cycles that follow a DRIVE cycle.
    assign cmp_fail = cmp_en && (q_fb != q_prev);

    // Next-state and next-output logic; bit 0 is issued on the accept edge.
    always_comb begin
        state_nx   = state;
        shift_nx   = shift_q;
        rem_nx     = rem_q;
        q_model_nx = q_model;
        j_nx       = 1'b0;
        k_nx       = 1'b0;
        done_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (pat_valid) begin
                    state_nx     = DRIVE;
                    {j_nx, k_nx} = excite(q_model, pat_data[0]);
                    q_model_nx   = pat_data[0];
                    shift_nx     = {1'b0, pat_data[WIDTH-1:1]};
                    rem_nx       = len_eff - LW'(1);
                end
            end
            DRIVE: begin
                if (rem_q == '0) begin
                    state_nx = CHECK;
                end else begin
                    {j_nx, k_nx} = excite(q_model, shift_q[0]);
                    q_model_nx   = shift_q[0];
                    shift_nx     = {1'b0, shift_q[WIDTH-1:1]};
                    rem_nx       = rem_q - LW'(1);
                end
            end
            CHECK: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath registers: pattern shifter, model of q, registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_q  <= '0;
            rem_q    <= '0;
            q_model  <= 1'b0;
            q_prev   <= 1'b0;
            cmp_en   <= 1'b0;
            j        <= 1'b0;
            k        <= 1'b0;
            done     <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            shift_q  <= shift_nx;
            rem_q    <= rem_nx;
            q_model  <= q_model_nx;
            q_prev   <= q_model;
            cmp_en   <= (state == DRIVE);
            j        <= j_nx;
            k        <= k_nx;
            done     <= done_nx;
            mismatch <= cmp_fail;
        end
    end

    // Saturating mismatch counter, cleared by each new pattern.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (accept) begin
            err_cnt <= '0;
        end else if (cmp_fail && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_jk_excite_driver.sv
// tb_jk_excite_driver: directed bench for jk_excite_driver with a behavioural
// JK flop closing the loop (q_fb can be overridden to inject errors).
module tb_jk_excite_driver;

    logic       clk;
    logic       rstn;
    logic       pat_valid;
    logic       pat_ready;
    logic [7:0] pat_data;
    logic [3:0] pat_len;
    logic       j;
    logic       k;
    logic       q_fb;
    logic       busy;
    logic       mismatch;
    logic [7:0] err_cnt;
    logic       done;
    logic [1:0] state_dbg;

    logic       q_ff;
    logic       force_en;
    logic       force_val;

    int checks;
    int failures;

`ifdef JK_EXCITE_TOGGLE_EN
    localparam logic [15:0] EXP_A6 = 16'hFCCC;
    localparam logic [15:0] EXP_0F = 16'h0300;
    localparam logic [15:0] EXP_01 = 16'h0003;
    localparam logic [15:0] EXP_00 = 16'h0003;
    localparam logic [15:0] EXP_03 = 16'h0003;
    localparam logic [31:0] EXP_AA0 = 32'd3;
`else
    localparam logic [15:0] EXP_A6 = 16'h9848;
    localparam logic [15:0] EXP_0F = 16'h0100;
    localparam logic [15:0] EXP_01 = 16'h0002;
    localparam logic [15:0] EXP_00 = 16'h0001;
    localparam logic [15:0] EXP_03 = 16'h0002;
    localparam logic [31:0] EXP_AA0 = 32'd1;
`endif

    jk_excite_driver #(.WIDTH(8), .ERR_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_data  (pat_data),
        .pat_len   (pat_len),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .busy      (busy),
        .mismatch  (mismatch),
        .err_cnt   (err_cnt),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural JK flop sharing clk and rstn with the driver.
    always @(posedge clk) begin
        if (!rstn) begin
            q_ff <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end

    assign q_fb = force_en ? force_val : q_ff;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one pattern: accept, n drive cycles, CHECK cycle, done cycle.
    task automatic run_pat(input string tag, input logic [7:0] data, input logic [3:0] len,
                           input logic [15:0] exp_jk, input int n,
                           input logic [31:0] exp_err, input logic [31:0] exp_mm);
        logic [15:0] pairs;
        int mm;
        pairs = exp_jk;
        mm = 0;
        @(negedge clk);
        pat_valid = 1'b1;
        pat_data  = data;
        pat_len   = len;
        @(posedge clk);
        #1 pat_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mm += 32'(mismatch);
            chk($sformatf("%s_jk%0d", tag, i), 32'({j, k}), 32'(pairs[2*i +: 2]));
            if (i == 0) begin
                chk({tag, "_busy"}, 32'(busy), 32'd1);
                chk({tag, "_ready"}, 32'(pat_ready), 32'd0);
            end
        end
        @(negedge clk);
        mm += 32'(mismatch);
        chk({tag, "_chk_jk"}, 32'({j, k}), 32'd0);
        chk({tag, "_chk_done"}, 32'(done), 32'd0);
        @(negedge clk);
        mm += 32'(mismatch);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err_cnt), exp_err);
        chk({tag, "_mm"}, 32'(mm), exp_mm);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        pat_valid = 1'b0;
        pat_data  = '0;
        pat_len   = '0;
        force_en  = 1'b0;
        force_val = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(pat_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_jk", 32'({j, k}), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mm", 32'(mismatch), 32'd0);

        // Full-length pattern, flop in the loop.
        run_pat("a6", 8'hA6, 4'd8, EXP_A6, 8, 32'd0, 32'd0);

        // q_fb stuck at 0 against an all-ones pattern (q already 1: all holds).
        force_en  = 1'b1;
        force_val = 1'b0;
        run_pat("stuck", 8'hFF, 4'd4, 16'h0000, 4, 32'd4, 32'd4);
        @(negedge clk);
        chk("stuck_hold_err", 32'(err_cnt), 32'd4);
        chk("stuck_no_done", 32'(done), 32'd0);
        force_en = 1'b0;

        // Length 0 means full width; accept clears the previous error count.
        run_pat("len0", 8'h0F, 4'd0, EXP_0F, 8, 32'd0, 32'd0);
        // Single-bit pattern: done two cycles after the drive cycle.
        run_pat("len1", 8'h01, 4'd1, EXP_01, 1, 32'd0, 32'd0);

        // Back-to-back with pat_valid held high.
        @(negedge clk);
        pat_valid = 1'b1;
        pat_data  = 8'h00;
        pat_len   = 4'd2;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_a_jk0", 32'({j, k}), 32'(EXP_00[1:0]));
        chk("b2b_a_ready", 32'(pat_ready), 32'd0);
        pat_data = 8'h03;
        @(negedge clk);
        chk("b2b_a_jk1", 32'({j, k}), 32'(EXP_00[3:2]));
        @(negedge clk);
        chk("b2b_a_chk_ready", 32'(pat_ready), 32'd0);
        @(negedge clk);
        chk("b2b_a_done", 32'(done), 32'd1);
        chk("b2b_a_ready_done", 32'(pat_ready), 32'd1);
        @(posedge clk);
        #1 pat_valid = 1'b0;
        @(negedge clk);
        chk("b2b_b_jk0", 32'({j, k}), 32'(EXP_03[1:0]));
        chk("b2b_b_busy", 32'(busy), 32'd1);
        chk("b2b_b_nodone", 32'(done), 32'd0);
        @(negedge clk);
        chk("b2b_b_jk1", 32'({j, k}), 32'(EXP_03[3:2]));
        @(negedge clk);
        @(negedge clk);
        chk("b2b_b_done", 32'(done), 32'd1);
        chk("b2b_b_err", 32'(err_cnt), 32'd0);

        // Reset in the middle of a pattern with one error already counted.
        @(negedge clk);
        force_en  = 1'b1;
        force_val = 1'b1;
        pat_valid = 1'b1;
        pat_data  = 8'hAA;
        pat_len   = 4'd8;
        @(posedge clk);
        #1 pat_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_jk0", 32'({j, k}), EXP_AA0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_err_before", 32'(err_cnt), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("rstmid_jk", 32'({j, k}), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_ready", 32'(pat_ready), 32'd1);
        chk("rstmid_err", 32'(err_cnt), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        rstn     = 1'b1;
        force_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid_nodone%0d", i), 32'(done), 32'd0);
        end

        // A fresh pattern after the abort starts from q=0 again.
        run_pat("after", 8'hA6, 4'd8, EXP_A6, 8, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
